wr_reg_dest_queue: RTL

- Parametrised successor to the write-register destination mux in the multicycle MIPS datapath.
- Selects the destination register (rt, rd, $ra, $sp) at issue and queues it in a small in-order FIFO until the write-back cycle retires it.
- Exposes a per-source hazard check against every pending destination so the control unit can stall reads of in-flight registers.
- Sits between the instruction register fields and the register file's write-address port.

---
 rtl/wr_reg_dest_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wr_reg_dest_queue.sv
// Write-register destination select plus in-order pending-destination FIFO.
// Exposes per-source hazard flags against every queued destination.

module wr_dest_match #(
  parameter int W = 5
) (
  input  logic         vld,
  input  logic [W-1:0] dest,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         hit_a,
  output logic         hit_b
);
  // $zero is never a hazard even though it may sit in the queue
  assign hit_a = vld && (dest == src_a) && (src_a != '0);
  assign hit_b = vld && (dest == src_b) && (src_b != '0);
endmodule

module wr_reg_dest_queue #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 4,
  parameter int RA_ADDR    = 31,
  parameter int SP_ADDR    = 29
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  selector,
  input  logic [REG_ADDR_W-1:0]       rt_field,
  input  logic [15:0]                 offset,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        retire,
  input  logic                        flush,
  output logic [REG_ADDR_W-1:0]       wr_addr,
  output logic                        wr_valid,
  input  logic [REG_ADDR_W-1:0]       src_a,
  input  logic [REG_ADDR_W-1:0]       src_b,
  output logic                        hazard_a,
  output logic                        hazard_b,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_q;
  logic [DEPTH-1:0]                 vld_q;
  logic [PTR_W-1:0]                 rd_ptr, wr_ptr;
  logic [CNT_W-1:0]                 cnt;
  logic [REG_ADDR_W-1:0]            rd_addr, sel_addr;
  logic [DEPTH-1:0]                 hit_a, hit_b;
  logic                             push, pop;
  logic                             unused_offset;

  assign unused_offset = ^offset;

  generate
    if (REG_ADDR_W >= 5) begin : g_rd_wide
      assign rd_addr = REG_ADDR_W'(offset[15:11]);
    end else begin : g_rd_narrow
      assign rd_addr = offset[11 +: REG_ADDR_W];
    end
  endgenerate

  always_comb begin
    sel_addr = rt_field;
    case (selector)
      2'b00:   sel_addr = rt_field;
      2'b01:   sel_addr = rd_addr;
      2'b10:   sel_addr = REG_ADDR_W'(RA_ADDR);
      default: sel_addr = REG_ADDR_W'(SP_ADDR);
    endcase
  end

  assign count       = cnt;
  assign full        = (cnt == CNT_W'(DEPTH));
  assign empty       = (cnt == '0);
  assign issue_ready = !full;
  // no retire bypass: a full queue refuses issue regardless of retire
  assign push        = issue_valid && !full;
  assign pop         = retire && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
      vld_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
    end else if (flush) begin
      vld_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (push) begin
        entry_q[wr_ptr] <= sel_addr;
        vld_q[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign wr_valid = !empty;
  assign wr_addr  = empty ? '0 : entry_q[rd_ptr];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
      wr_dest_match #(.W(REG_ADDR_W)) u_match (
        .vld   (vld_q[i]),
        .dest  (entry_q[i]),
        .src_a (src_a),
        .src_b (src_b),
        .hit_a (hit_a[i]),
        .hit_b (hit_b[i])
      );
    end
  endgenerate

  assign hazard_a = |hit_a;
  assign hazard_b = |hit_b;
endmodule
